// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, state encoding and line bundle for the data cache.
// Shared by the cache controller and its storage array.
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 8;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_W-1:0]   tag;
        logic [BLOCK_W-1:0] data;
    } line_t;

    function automatic logic [7:0] pick_byte(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage for the direct-mapped cache.
// Byte-write port, block-install port and a combinational line read.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    output line_t               rd_line,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [7:0]          wr_byte,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;
    logic [TAG_W-1:0]      tag  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
            dirty[fill_index] <= 1'b0;
        end else if (wr_en) begin
            dirty[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag[fill_index]  <= fill_tag;
            data[fill_index] <= fill_data;
        end else if (wr_en) begin
            data[wr_index][{wr_offset, 3'b000} +: 8] <= wr_byte;
        end
    end

    always_comb begin
        rd_line.valid = valid[rd_index];
        rd_line.dirty = dirty[rd_index];
        rd_line.tag   = tag[rd_index];
        rd_line.data  = data[rd_index];
    end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back write-allocate data cache controller.
// Hit logic, miss FSM and memory-side muxing around dcache_array.
module dcache
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                READ,
    input  logic                WRITE,
    input  logic [7:0]          ADDRESS,
    input  logic [7:0]          WRITEDATA,
    output logic [7:0]          READDATA,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [5:0]          MEM_ADDRESS,
    output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]  MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [INDEX_W-1:0]  arr_index;
    logic                rd_seen;
    logic                wr_seen;
    logic                idle;
    logic                hit;
    logic                miss;
    line_t               line;

    assign idle      = (state == S_IDLE);
    assign arr_index = idle ? ADDRESS[4:2] : req_index;
    assign hit       = line.valid && (line.tag == ADDRESS[7:5]);
    assign miss      = (READ | WRITE) & ~hit;

    assign BUSYWAIT = RESET & (~idle | miss);
    assign READDATA = (READ && hit) ? pick_byte(line.data, ADDRESS[1:0]) : 8'h00;

    dcache_array u_array (
        .clk        (CLK),
        .rst_n      (RESET),
        .rd_index   (arr_index),
        .rd_line    (line),
        .wr_en      (idle & WRITE & hit),
        .wr_index   (ADDRESS[4:2]),
        .wr_offset  (ADDRESS[1:0]),
        .wr_byte    (WRITEDATA),
        .fill_en    (state == S_UPDATE),
        .fill_index (req_index),
        .fill_tag   (req_tag),
        .fill_data  (MEM_READDATA)
    );

    // Completion needs the strobe high a cycle earlier, so a late-rising
    // MEM_BUSYWAIT is never mistaken for a finished transaction.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (miss)
                    next_state = (line.valid && line.dirty) ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                if (!MEM_BUSYWAIT && wr_seen)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                if (!MEM_BUSYWAIT && rd_seen)
                    next_state = S_UPDATE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state)
            S_WRITEBACK: begin
                MEM_ADDRESS   = {line.tag, req_index};
                MEM_WRITEDATA = line.data;
            end
            S_FETCH: MEM_ADDRESS = {req_tag, req_index};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            rd_seen   <= 1'b0;
            wr_seen   <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
        end else begin
            state     <= next_state;
            MEM_READ  <= (next_state == S_FETCH);
            MEM_WRITE <= (next_state == S_WRITEBACK);
            rd_seen   <= MEM_READ;
            wr_seen   <= MEM_WRITE;
            if (idle && miss) begin
                req_tag   <= ADDRESS[7:5];
                req_index <= ADDRESS[4:2];
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed test of dcache against a latency-modelled memory.
// Expected values are hand-computed from the block contents below.
module tb_dcache;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory raises busy one edge after it sees a strobe and holds it
    // LAT cycles, giving F = W = LAT + 2 = 5 strobe cycles per transaction.
    localparam int LAT = 3;

    logic [31:0] mem [64];
    int          busy_cnt;
    logic [1:0]  done_kind;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= 32'h0;
            busy_cnt     <= 0;
            done_kind    <= 2'b00;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h44332211;
            mem[7]  <= 32'h07070707;
            mem[8]  <= 32'h88776655;
            mem[16] <= 32'hDDCCBBAA;
            mem[17] <= 32'h12345678;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                MEM_BUSYWAIT <= 1'b0;
                done_kind    <= {MEM_READ, MEM_WRITE};
                if (MEM_READ)  MEM_READDATA <= mem[MEM_ADDRESS];
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end
        end else if ({MEM_READ, MEM_WRITE} == 2'b00) begin
            done_kind <= 2'b00;
        end else if ({MEM_READ, MEM_WRITE} != done_kind) begin
            MEM_BUSYWAIT <= 1'b1;
            busy_cnt     <= LAT;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          stall;
    int          r_pulses;
    int          w_pulses;
    logic [5:0]  r_addr;
    logic [5:0]  w_addr;
    logic [31:0] w_data;
    logic [7:0]  rdata;

    // One CPU access: drive after an edge, count stall cycles at negedges,
    // log memory strobes, capture READDATA, then hold one more edge.
    task automatic access(input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
        logic pr;
        logic pw;
        @(posedge CLK);
        #1;
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        stall = 0;
        r_pulses = 0;
        w_pulses = 0;
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        pr = 1'b0;
        pw = 1'b0;
        @(negedge CLK);
        while (BUSYWAIT && stall < 100) begin
            stall++;
            if (MEM_READ && !pr) begin
                r_pulses++;
                r_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE && !pw) begin
                w_pulses++;
                w_addr = MEM_ADDRESS;
                w_data = MEM_WRITEDATA;
            end
            pr = MEM_READ;
            pw = MEM_WRITE;
            @(negedge CLK);
        end
        if (stall >= 100) chk("stall_timeout", stall, 0);
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        int n;
        READ = 1'b0;
        WRITE = 1'b0;
        ADDRESS = 8'h00;
        WRITEDATA = 8'h00;
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        chk("rst_busywait", BUSYWAIT, 0);
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        chk("rst_mem_addr", MEM_ADDRESS, 0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 0);
        chk("rst_readdata", READDATA, 0);
        chk("rst_valid", u_dut.u_array.valid, 0);
        #9 RESET = 1'b1;

        access(1, 0, 8'h00, 8'h00);
        chk("load_stall", stall, 7);
        chk("load_rd_pulses", r_pulses, 1);
        chk("load_rd_addr", r_addr, 6'h00);
        chk("load_wr_pulses", w_pulses, 0);
        chk("load_data", rdata, 8'h11);

        access(1, 0, 8'h03, 8'h00);
        chk("hit_stall", stall, 0);
        chk("hit_data", rdata, 8'h44);

        access(0, 1, 8'h01, 8'hAA);
        chk("wr_hit_stall", stall, 0);
        access(1, 0, 8'h01, 8'h00);
        chk("wr_hit_data", rdata, 8'hAA);
        chk("wr_hit_dirty", u_dut.u_array.dirty[0], 1);

        access(1, 0, 8'h20, 8'h00);
        chk("dirty_stall", stall, 12);
        chk("dirty_wr_pulses", w_pulses, 1);
        chk("dirty_wr_addr", w_addr, 6'h00);
        chk("dirty_wr_data", w_data, 32'h4433AA11);
        chk("dirty_rd_addr", r_addr, 6'h08);
        chk("dirty_data", rdata, 8'h55);
        chk("dirty_mem0", mem[0], 32'h4433AA11);

        access(1, 0, 8'h20, 8'h00);
        chk("clean_hit_stall", stall, 0);
        access(1, 0, 8'h40, 8'h00);
        chk("clean_stall", stall, 7);
        chk("clean_wr_pulses", w_pulses, 0);
        chk("clean_rd_addr", r_addr, 6'h10);
        chk("clean_data", rdata, 8'hAA);

        access(0, 1, 8'h1E, 8'h5C);
        chk("wmiss_stall", stall, 7);
        chk("wmiss_rd_addr", r_addr, 6'h07);
        access(1, 0, 8'h1E, 8'h00);
        chk("wmiss_byte2", rdata, 8'h5C);
        access(1, 0, 8'h1C, 8'h00);
        chk("wmiss_byte0", rdata, 8'h07);
        chk("wmiss_dirty", u_dut.u_array.dirty[7], 1);

        @(posedge CLK);
        #1;
        READ = 1'b1;
        ADDRESS = 8'h44;
        repeat (3) @(negedge CLK);
        chk("mid_fetch_strobe", MEM_READ, 1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_mem_read", MEM_READ, 0);
        chk("mid_rst_busywait", BUSYWAIT, 0);
        chk("mid_rst_valid", u_dut.u_array.valid, 0);
        chk("mid_rst_dirty", u_dut.u_array.dirty, 0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("reissue_miss", BUSYWAIT, 1);
        n = 0;
        @(negedge CLK);
        while (BUSYWAIT && n < 100) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 100) chk("reissue_timeout", n, 0);
        chk("reissue_data", READDATA, 8'h78);
        @(posedge CLK);
        #1;
        READ = 1'b0;
        repeat (2) @(posedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU's load/store path and the word-organised data memory. The CPU's byte-wide `lwd/lwi/swd/swi` accesses hit the cache without stalling. Misses raise `BUSYWAIT`, which freezes the PC and control. While the CPU is frozen, the cache evicts a dirty block if needed and then fetches the 4-byte block from memory.

## Interface
- Parameters: none; geometry is fixed at 8 blocks × 4 bytes (constants in package).
- `CLK` in 1 — system clock, rising edge.
- `RESET` in 1 — asynchronous, active-low reset.
- `READ` in 1 — CPU load request, held until `BUSYWAIT` low.
- `WRITE` in 1 — CPU store request, held until `BUSYWAIT` low. Never asserted together with `READ`.
- `ADDRESS` in 8 — byte address. Fields: tag [7:5], index [4:2], offset [1:0].
- `WRITEDATA` in 8 — store data.
- `READDATA` out 8 — load data, valid when `READ` is high and `BUSYWAIT` is low.
- `BUSYWAIT` out 1 — CPU stall.
- `MEM_READ` out 1 — block fetch strobe.
- `MEM_WRITE` out 1 — block writeback strobe.
- `MEM_ADDRESS` out 6 — block address {tag, index}.
- `MEM_WRITEDATA` out 32 — block data. Byte 0 is in [7:0].
- `MEM_READDATA` in 32 — fetched block.
- `MEM_BUSYWAIT` in 1 — memory busy; low means the transaction is complete.

## Operation
- Storage per entry:
  - valid bit, dirty bit, 3-bit tag, 4 × 8-bit data.
- Hit condition:
  - `valid[index] && tag[index]==ADDRESS[7:5]`, evaluated combinationally.
- Read hit:
  - `READDATA` = byte `offset` of the block, combinational.
  - `BUSYWAIT`=0.
- Write hit:
  - `BUSYWAIT`=0.
  - At the next rising edge, write the byte into the block and set dirty=1.
- Miss (`READ|WRITE` with no hit, in IDLE):
  - `BUSYWAIT`=1 combinationally.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise FETCH.
- FSM states:
  - **IDLE:**
    - All memory strobes are 0.
    - `BUSYWAIT` = (READ|WRITE) & !hit.
  - **WRITEBACK:**
    - `MEM_WRITE`=1, `MEM_ADDRESS`={victim tag, index}, `MEM_WRITEDATA`=victim block.
    - Leaves for FETCH at the first rising edge where `MEM_BUSYWAIT`=0 **and** the strobe was already high in the previous cycle. This guards against the memory's delayed assertion of `MEM_BUSYWAIT`.
  - **FETCH:**
    - `MEM_READ`=1, `MEM_ADDRESS`={request tag, index}.
    - Leaves for UPDATE under the same completion rule as WRITEBACK.
  - **UPDATE** (one cycle):
    - At its rising edge, install `MEM_READDATA`, set tag, valid=1, dirty=0.
    - Go to IDLE.
- After UPDATE the request is re-evaluated in IDLE and hits:
  - a load returns data;
  - a store writes at the following edge.
- Memory strobes are registered outputs of the state. They never glitch high in IDLE.
- `BUSYWAIT`=1 in every non-IDLE state.
- Request dropped mid-miss (not expected from the CPU): the in-flight transaction still completes and the block is installed.
- Reset mid-operation:
  - State → IDLE immediately.
  - All valid and dirty bits cleared.
  - Strobes drop asynchronously.
  - Dirty data is lost, which is intended.

## Timing
- Reset values:
  - `BUSYWAIT`=0, `MEM_READ`=0, `MEM_WRITE`=0, `MEM_ADDRESS`=0, `MEM_WRITEDATA`=0.
  - `READDATA`=0 while invalid or not reading.
  - All valid and dirty bits = 0.
- Hit: zero stall cycles.
- Clean miss stall, where F = FETCH cycles until `MEM_BUSYWAIT` falls:
  - 1 (IDLE detect) + F + 1 (UPDATE) cycles.
  - A store then commits at the edge ending the first post-UPDATE IDLE cycle.
- Dirty miss stall, where W = WRITEBACK cycles: 1 + W + F + 1 cycles.
- `MEM_READDATA` is sampled only at the UPDATE edge. It is ignored otherwise.

## Structure
- Package `dcache_pkg`:
  - `TAG_W`=3, `INDEX_W`=3, `OFFSET_W`=2, `BLOCK_W`=32, `NUM_BLOCKS`=8.
  - State encoding IDLE/WRITEBACK/FETCH/UPDATE.
- Sub-module `dcache_array` holds the valid/dirty/tag/data storage:
  - async-cleared valid and dirty bits;
  - byte-write port;
  - block-install port;
  - combinational read.
- The FSM, hit logic and memory-side muxing stay in `dcache`.

## Test plan
- **Reset then load:** `RESET` low, release, then `READ` @0x00, with memory busy 5 cycles returning 0x44332211.
  - `BUSYWAIT` high 7 cycles, one `MEM_READ` to block 0x00, then `READDATA`=0x11.
  - `READ` @0x03 → 0x44 with no stall.
- **Write hit:** after the above, `WRITE` 0xAA @0x01.
  - No stall; a subsequent read @0x01 returns 0xAA; dirty[0]=1.
- **Dirty eviction:** `READ` @0x20 (same index 0, tag 1).
  - `MEM_WRITE` with `MEM_ADDRESS`=0x00 and `MEM_WRITEDATA`=0x4433AA11, then `MEM_READ` with `MEM_ADDRESS`=0x08.
  - Stall = 1+W+F+1 cycles.
- **Clean eviction:** read @0x20, then read @0x40.
  - No `MEM_WRITE`; only `MEM_READ` to 0x10.
- **Write miss allocate:** `WRITE` 0x5C @0x1E on a cold index.
  - Fetch of block 0x07, then byte 2 = 0x5C, dirty=1.
- **Reset mid-FETCH:** assert `RESET` during FETCH.
  - Strobes and `BUSYWAIT` drop in the same cycle.
  - The reissued read misses again.
